instr_encoder: RTL and testbench

Sequential RISC-V instruction encoder: the inverse of the immediate generator. It accepts decoded fields (opcode, funct3, register indices, 32-bit immediate, I/S format select) over a valid/ready handshake. It packs them into 32-bit I-type or S-type instruction words and streams them, with a byte address, toward instruction memory. Used by the bench and boot loader to build programs for the single-cycle core.

---
 rtl/riscv_defs.sv | 54 +++++
 rtl/instr_encoder_imm_pack.sv | 35 +++
 rtl/instr_encoder.sv | 200 ++++++++++++++++++++
 tb/tb_instr_encoder.sv | 283 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/riscv_defs.sv
// Shared RISC-V definitions for the instruction encoder slice.
// Holds the immediate-format selects, opcode constants, the encoder state
// encoding and the field packing helpers used by imm_pack.
package riscv_defs;

    // Immediate format select
    localparam logic IMM_SRC_I = 1'b0;
    localparam logic IMM_SRC_S = 1'b1;

    // Opcodes used by the boot loader and bench programs
    localparam logic [6:0] OP_IMM   = 7'b0010011;
    localparam logic [6:0] OP_LOAD  = 7'b0000011;
    localparam logic [6:0] OP_STORE = 7'b0100011;

    // Signed 12-bit immediate range
    localparam int IMM12_MIN = -2048;
    localparam int IMM12_MAX = 2047;

    // Encoder session states
    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_LOAD = 2'd1,
        ST_FULL = 2'd2
    } enc_state_e;

    // I-type layout: imm[11:0] | rs1 | funct3 | rd | opcode
    function automatic logic [31:0] pack_itype(
        input logic [6:0]  opcode,
        input logic [2:0]  funct3,
        input logic [4:0]  rd,
        input logic [4:0]  rs1,
        input logic [11:0] imm12
    );
        return {imm12, rs1, funct3, rd, opcode};
    endfunction

    // S-type layout: imm[11:5] | rs2 | rs1 | funct3 | imm[4:0] | opcode
    function automatic logic [31:0] pack_stype(
        input logic [6:0]  opcode,
        input logic [2:0]  funct3,
        input logic [4:0]  rs1,
        input logic [4:0]  rs2,
        input logic [11:0] imm12
    );
        return {imm12[11:5], rs2, rs1, funct3, imm12[4:0], opcode};
    endfunction

    // True when a 32-bit two's-complement value fits a signed 12-bit field,
    // i.e. bits [31:11] are a pure sign extension.
    function automatic logic fits_imm12(input logic [31:0] imm);
        return (imm[31:11] == 21'h000000) || (imm[31:11] == 21'h1FFFFF);
    endfunction

endpackage

// File: rtl/instr_encoder_imm_pack.sv
// imm_pack: combinational field packer for the instruction encoder.
// Builds an I-type or S-type word from decoded fields and flags whether the
// immediate is representable in 12 signed bits. rd is ignored for S-type and
// rs2 is ignored for I-type.
module imm_pack
    import riscv_defs::*;
(
    input  logic        imm_src,
    input  logic [6:0]  opcode,
    input  logic [2:0]  funct3,
    input  logic [4:0]  rd,
    input  logic [4:0]  rs1,
    input  logic [4:0]  rs2,
    input  logic [31:0] imm,
    output logic [31:0] word,
    output logic        in_range
);

    // Select the layout for the requested format; out-of-range immediates
    // are truncated to their low 12 bits here, the top decides what to do.
    always_comb begin
        word = 32'h0000_0000;
        if (imm_src == IMM_SRC_S) begin
            word = pack_stype(opcode, funct3, rs1, rs2, imm[11:0]);
        end else begin
            word = pack_itype(opcode, funct3, rd, rs1, imm[11:0]);
        end
    end

    // Range flag for the optional rejection path in the top
    always_comb begin
        in_range = fits_imm12(imm);
    end

endmodule

// File: rtl/instr_encoder.sv
// instr_encoder: sequential RISC-V I/S-type instruction encoder.
// Accepts decoded field bundles over valid/ready, packs them into 32-bit
// words and streams them with consecutive byte addresses toward instruction
// memory. A session holds up to DEPTH words, then parks in FULL until the
// next start.
//
// Build option: define INSTR_ENC_RANGE_CHECK_EN to reject (consume, do not
// emit, pulse err) bundles whose immediate does not fit 12 signed bits.
// Without it the immediate is truncated and every bundle is emitted.
module instr_encoder
    import riscv_defs::*;
#(
    parameter int          DEPTH     = 64,
    parameter logic [31:0] BASE_ADDR = 32'h0000_0000
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        start,
    input  logic        in_valid,
    output logic        in_ready,
    input  logic        imm_src,
    input  logic [6:0]  opcode,
    input  logic [2:0]  funct3,
    input  logic [4:0]  rd,
    input  logic [4:0]  rs1,
    input  logic [4:0]  rs2,
    input  logic [31:0] imm,
    output logic        out_valid,
    input  logic        out_ready,
    output logic [31:0] instr,
    output logic [31:0] addr,
    output logic        err,
    output logic        full
);

    localparam int CNT_W = $clog2(DEPTH + 1);

    enc_state_e        state_r;
    enc_state_e        state_next_s;
    logic [CNT_W-1:0]  count_r;
    logic [31:0]       next_addr_r;

    logic              out_valid_r;
    logic [31:0]       instr_r;
    logic [31:0]       addr_r;
    logic              err_r;
    logic              full_r;

    logic              in_ready_s;
    logic              accept_s;
    logic              emit_s;
    logic              reject_s;
    logic              last_s;
    logic [31:0]       pack_word_s;
    logic              pack_in_range_s;

    imm_pack u_imm_pack (
        .imm_src  (imm_src),
        .opcode   (opcode),
        .funct3   (funct3),
        .rd       (rd),
        .rs1      (rs1),
        .rs2      (rs2),
        .imm      (imm),
        .word     (pack_word_s),
        .in_range (pack_in_range_s)
    );

    // Handshake: only LOAD accepts, start blocks acceptance, and a held word
    // blocks acceptance unless it is being drained this cycle.
    always_comb begin
        in_ready_s = 1'b0;
        if ((state_r == ST_LOAD) && !start) begin
            in_ready_s = !out_valid_r || out_ready;
        end else begin
            in_ready_s = 1'b0;
        end
        accept_s = in_valid && in_ready_s;
        last_s   = (count_r == CNT_W'(DEPTH - 1));
    end

`ifdef INSTR_ENC_RANGE_CHECK_EN
    // Out-of-range bundles are consumed but produce no word, only an err pulse
    always_comb begin
        emit_s   = accept_s && pack_in_range_s;
        reject_s = accept_s && !pack_in_range_s;
    end
`else
    logic unused_in_range_s;
    assign unused_in_range_s = pack_in_range_s;

    // Every accepted bundle is emitted; the immediate is simply truncated
    always_comb begin
        emit_s   = accept_s;
        reject_s = 1'b0;
    end
`endif

    // Session state register
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_r <= ST_IDLE;
        end else begin
            state_r <= state_next_s;
        end
    end

    // Next-state logic: start always (re)opens a session, the last emitted
    // word of a session closes it.
    always_comb begin
        state_next_s = state_r;
        case (state_r)
            ST_IDLE: begin
                if (start) begin
                    state_next_s = ST_LOAD;
                end else begin
                    state_next_s = ST_IDLE;
                end
            end
            ST_LOAD: begin
                if (start) begin
                    state_next_s = ST_LOAD;
                end else if (emit_s && last_s) begin
                    state_next_s = ST_FULL;
                end else begin
                    state_next_s = ST_LOAD;
                end
            end
            ST_FULL: begin
                if (start) begin
                    state_next_s = ST_LOAD;
                end else begin
                    state_next_s = ST_FULL;
                end
            end
            default: begin
                state_next_s = ST_IDLE;
            end
        endcase
    end

    // Word count and next byte address; start rewinds both, emission advances
    // them (address wraps naturally at 32 bits).
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            count_r     <= {CNT_W{1'b0}};
            next_addr_r <= BASE_ADDR;
        end else if (start) begin
            count_r     <= {CNT_W{1'b0}};
            next_addr_r <= BASE_ADDR;
        end else if (emit_s) begin
            count_r     <= count_r + {{(CNT_W-1){1'b0}}, 1'b1};
            next_addr_r <= next_addr_r + 32'd4;
        end else begin
            count_r     <= count_r;
            next_addr_r <= next_addr_r;
        end
    end

    // Output word register: a new word replaces the held one (covering a
    // same-cycle drain), otherwise a drain empties it. start leaves it alone.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            out_valid_r <= 1'b0;
            instr_r     <= 32'h0000_0000;
            addr_r      <= 32'h0000_0000;
        end else if (emit_s) begin
            out_valid_r <= 1'b1;
            instr_r     <= pack_word_s;
            addr_r      <= next_addr_r;
        end else if (out_ready) begin
            out_valid_r <= 1'b0;
            instr_r     <= instr_r;
            addr_r      <= addr_r;
        end else begin
            out_valid_r <= out_valid_r;
            instr_r     <= instr_r;
            addr_r      <= addr_r;
        end
    end

    // Status flags: err pulses the cycle after a rejection, full tracks FULL
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            err_r  <= 1'b0;
            full_r <= 1'b0;
        end else begin
            err_r  <= reject_s;
            full_r <= (state_next_s == ST_FULL);
        end
    end

    assign in_ready  = in_ready_s;
    assign out_valid = out_valid_r;
    assign instr     = instr_r;
    assign addr      = addr_r;
    assign err       = err_r;
    assign full      = full_r;

endmodule

// File: tb/tb_instr_encoder.sv
// Self-checking bench for instr_encoder: directed steps from the test plan
// followed by randomized traffic, all compared against a behavioural model
// of the session/stream rules kept in this file.
module tb_instr_encoder;
    import riscv_defs::*;

    localparam int          TB_DEPTH = 4;
    localparam logic [31:0] TB_BASE  = 32'h0000_1000;
`ifdef INSTR_ENC_RANGE_CHECK_EN
    localparam bit RANGE_EN = 1'b1;
`else
    localparam bit RANGE_EN = 1'b0;
`endif

    logic        clk;
    logic        rst;
    logic        start;
    logic        in_valid;
    logic        in_ready;
    logic        imm_src;
    logic [6:0]  opcode;
    logic [2:0]  funct3;
    logic [4:0]  rd;
    logic [4:0]  rs1;
    logic [4:0]  rs2;
    logic [31:0] imm;
    logic        out_valid;
    logic        out_ready;
    logic [31:0] instr;
    logic [31:0] addr;
    logic        err;
    logic        full;

    int n_checks = 0;
    int n_fail   = 0;

    // Behavioural model state
    bit          m_loading;
    bit          m_full;
    int          m_count;
    logic [31:0] m_next;
    bit          m_ov;
    logic [31:0] m_instr;
    logic [31:0] m_addr;
    bit          m_err;

    instr_encoder #(.DEPTH(TB_DEPTH), .BASE_ADDR(TB_BASE)) dut (
        .clk       (clk),
        .rst       (rst),
        .start     (start),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .imm_src   (imm_src),
        .opcode    (opcode),
        .funct3    (funct3),
        .rd        (rd),
        .rs1       (rs1),
        .rs2       (rs2),
        .imm       (imm),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .instr     (instr),
        .addr      (addr),
        .err       (err),
        .full      (full)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    // Instruction word from the field rules, built by weighted sums
    function automatic logic [31:0] ref_encode(input bit s, input logic [6:0] op,
                                               input logic [2:0] f3, input logic [4:0] rdv,
                                               input logic [4:0] rs1v, input logic [4:0] rs2v,
                                               input logic [31:0] iv);
        int unsigned low12;
        int unsigned w;
        low12 = iv % 32'd4096;
        if (s)
            w = (low12 / 32'd32) * (32'd1 << 25) + 32'(rs2v) * (32'd1 << 20)
              + 32'(rs1v) * (32'd1 << 15) + 32'(f3) * (32'd1 << 12)
              + (low12 % 32'd32) * (32'd1 << 7) + 32'(op);
        else
            w = low12 * (32'd1 << 20) + 32'(rs1v) * (32'd1 << 15)
              + 32'(f3) * (32'd1 << 12) + 32'(rdv) * (32'd1 << 7) + 32'(op);
        return w;
    endfunction

    function automatic bit ref_in_range(input logic [31:0] iv);
        int v;
        v = $signed(iv);
        return (v >= -2048) && (v <= 2047);
    endfunction

    task automatic model_reset();
        m_loading = 1'b0; m_full = 1'b0; m_count = 0; m_next = TB_BASE;
        m_ov = 1'b0; m_instr = 32'h0; m_addr = 32'h0; m_err = 1'b0;
    endtask

    task automatic check_outputs(input string phase);
        check({phase, ".out_valid"}, {31'd0, out_valid}, {31'd0, m_ov});
        check({phase, ".instr"},     instr,              m_instr);
        check({phase, ".addr"},      addr,               m_addr);
        check({phase, ".err"},       {31'd0, err},       {31'd0, m_err});
        check({phase, ".full"},      {31'd0, full},      {31'd0, m_full});
    endtask

    // One clock: check in_ready mid-cycle, advance the model, check outputs
    task automatic cycle(input string phase);
        bit rdy;
        bit acc;
        bit ok;
        @(negedge clk);
        rdy = !rst && m_loading && !start && (!m_ov || out_ready);
        check({phase, ".in_ready"}, {31'd0, in_ready}, {31'd0, rdy});
        acc = in_valid && rdy;
        ok  = acc && (!RANGE_EN || ref_in_range(imm));
        if (!rst) begin
            m_err = acc && !ok;
            if (ok) begin
                m_ov    = 1'b1;
                m_instr = ref_encode(imm_src, opcode, funct3, rd, rs1, rs2, imm);
                m_addr  = m_next;
            end else if (out_ready) begin
                m_ov = 1'b0;
            end
            if (start) begin
                m_loading = 1'b1; m_full = 1'b0; m_count = 0; m_next = TB_BASE;
            end else if (ok) begin
                m_next  = m_next + 32'd4;
                m_count = m_count + 1;
                if (m_count == TB_DEPTH) begin
                    m_full = 1'b1; m_loading = 1'b0;
                end
            end
        end
        @(posedge clk);
        #1;
        check_outputs(phase);
    endtask

    task automatic drive(input bit s, input logic [6:0] op, input logic [2:0] f3,
                         input logic [4:0] rdv, input logic [4:0] rs1v,
                         input logic [4:0] rs2v, input logic [31:0] iv);
        in_valid = 1'b1; imm_src = s; opcode = op; funct3 = f3;
        rd = rdv; rs1 = rs1v; rs2 = rs2v; imm = iv;
    endtask

    function automatic logic [31:0] rand_imm();
        int sel;
        int b;
        sel = $urandom_range(0, 3);
        case (sel)
            0: return 32'($urandom_range(0, 4095)) - 32'd2048;
            1: return $urandom;
            default: begin
                b = $urandom_range(0, 3);
                case (b)
                    0: return 32'd2047;
                    1: return 32'hFFFF_F800;
                    2: return 32'd2048;
                    default: return 32'hFFFF_F7FF;
                endcase
            end
        endcase
    endfunction

    initial begin
        rst = 1'b1; start = 1'b0; in_valid = 1'b0; out_ready = 1'b1;
        imm_src = IMM_SRC_I; opcode = 7'd0; funct3 = 3'd0;
        rd = 5'd0; rs1 = 5'd0; rs2 = 5'd0; imm = 32'd0;
        model_reset();

        // Reset state
        repeat (2) @(posedge clk);
        #1;
        check_outputs("reset");
        check("reset.in_ready", {31'd0, in_ready}, 32'd0);
        rst = 1'b0;

        // IDLE ignores bundles
        drive(1'b0, OP_IMM, 3'd0, 5'd1, 5'd0, 5'd0, 32'd5);
        cycle("idle");

        // start wins over a simultaneous bundle
        start = 1'b1;
        cycle("start");
        start = 1'b0;

        // Test-plan vectors, back to back with out_ready=1
        drive(IMM_SRC_I, OP_IMM, 3'd0, 5'd1, 5'd0, 5'd0, 32'd5);
        cycle("v1");
        check("v1.const_instr", instr, 32'h0050_0093);
        check("v1.const_addr", addr, TB_BASE);
        drive(IMM_SRC_S, OP_STORE, 3'd2, 5'd0, 5'd1, 5'd2, 32'd8);
        cycle("v2");
        check("v2.const_instr", instr, 32'h0020_A423);
        check("v2.const_addr", addr, TB_BASE + 32'd4);
        drive(IMM_SRC_I, OP_IMM, 3'd0, 5'd3, 5'd0, 5'd0, 32'hFFFF_FFFF);
        cycle("v3");
        check("v3.const_instr", instr, 32'hFFF0_0193);
        check("v3.const_addr", addr, TB_BASE + 32'd8);
        drive(IMM_SRC_I, OP_IMM, 3'd0, 5'd1, 5'd0, 5'd0, 32'd2048);
        cycle("v4");
`ifdef INSTR_ENC_RANGE_CHECK_EN
        check("v4.const_err", {31'd0, err}, 32'd1);
        check("v4.const_ov", {31'd0, out_valid}, 32'd0);
        drive(IMM_SRC_I, OP_IMM, 3'd0, 5'd1, 5'd0, 5'd0, 32'd5);
        cycle("v5");
        check("v5.const_addr", addr, TB_BASE + 32'd12);
`else
        check("v4.const_instr", instr, 32'h8000_0093);
        check("v4.const_addr", addr, TB_BASE + 32'd12);
`endif
        check("full.const", {31'd0, full}, 32'd1);
        cycle("full_hold");

        // Restart from FULL, then backpressure
        in_valid = 1'b0; start = 1'b1;
        cycle("restart");
        start = 1'b0; out_ready = 1'b0;
        drive(IMM_SRC_I, OP_LOAD, 3'd2, 5'd7, 5'd4, 5'd0, 32'd16);
        cycle("bp_accept");
        check("bp.const_addr", addr, TB_BASE);
        drive(IMM_SRC_S, OP_STORE, 3'd2, 5'd0, 5'd4, 5'd9, 32'hFFFF_FFF0);
        repeat (3) cycle("bp_stall");
        out_ready = 1'b1;
        cycle("bp_release");
        check("bp.const_ov", {31'd0, out_valid}, 32'd1);
        check("bp.const_addr2", addr, TB_BASE + 32'd4);

        // Randomized traffic
        for (int i = 0; i < 400; i++) begin
            start     = ($urandom_range(0, 19) == 0);
            out_ready = ($urandom_range(0, 3) != 0);
            if ($urandom_range(0, 3) != 0) begin
                drive($urandom_range(0, 1) == 1,
                      ($urandom_range(0, 1) == 1) ? OP_IMM : 7'($urandom),
                      3'($urandom), 5'($urandom), 5'($urandom), 5'($urandom), rand_imm());
            end else begin
                in_valid = 1'b0;
            end
            cycle("rand");
        end

        // Mid-stream reset drops the pending word immediately
        start = 1'b1; in_valid = 1'b0; out_ready = 1'b0;
        cycle("pre_rst_start");
        start = 1'b0;
        drive(IMM_SRC_I, OP_IMM, 3'd1, 5'd2, 5'd3, 5'd0, 32'd100);
        cycle("pre_rst_word");
        #3;
        rst = 1'b1;
        #1;
        model_reset();
        check("rst_async.out_valid", {31'd0, out_valid}, 32'd0);
        check("rst_async.full", {31'd0, full}, 32'd0);
        check("rst_async.instr", instr, 32'd0);
        cycle("rst_hold");
        #2;
        rst = 1'b0;
        in_valid = 1'b0; out_ready = 1'b1; start = 1'b1;
        cycle("post_rst_start");
        start = 1'b0;
        drive(IMM_SRC_I, OP_IMM, 3'd0, 5'd1, 5'd0, 5'd0, 32'd5);
        cycle("post_rst_word");
        check("post_rst.const_addr", addr, TB_BASE);
        in_valid = 1'b0;
        cycle("drain");

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
